// File: rtl/tick_counter_bank.sv
// tick_counter_bank: NCH independent WIDTH-bit up-counters.
// A shared free-running prescaler produces one tick every PERIOD clocks.
// Each channel can load a value, take a step on a tick, or hold.
// o is a flat bus: channel i sits at o[i*WIDTH +: WIDTH], channel 0 at the LSBs.
// ovf is a registered pulse, one cycle wide, marking each carry, borrow or clamp.
// Optional feature macro: TICK_COUNTER_BANK_DOWN_EN adds the per-channel
// dir input. When dir is 1 the channel counts down on a tick.
module tick_counter_bank #(
   parameter int NCH      = 2,
   parameter int WIDTH    = 3,
   parameter int PERIOD   = 5,
   parameter int STEP     = 1,
   parameter int INIT     = 0,
   parameter int SATURATE = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NCH-1:0]       en,
   input  logic [NCH-1:0]       load,
   input  logic [NCH*WIDTH-1:0] load_val,
`ifdef TICK_COUNTER_BANK_DOWN_EN
   input  logic [NCH-1:0]       dir,
`endif
   output logic [NCH*WIDTH-1:0] o,
   output logic                 tick,
   output logic [NCH-1:0]       ovf
);

   // With PERIOD=1 the prescaler collapses to a single bit that stays at 0.
   localparam int              PW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [PW-1:0]   LAST   = PW'(PERIOD - 1);
   localparam logic [WIDTH:0]  STEP_X = (WIDTH + 1)'(STEP);
   localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);
   localparam logic [WIDTH-1:0] MAX_V  = '1;
   localparam logic [WIDTH-1:0] MIN_V  = '0;

   logic [PW-1:0] prescaler_reg;
   logic [PW-1:0] prescaler_next;
   logic          at_last;

   // Compute the next prescaler state. It wraps after PERIOD-1.
   always_comb begin
      at_last        = (prescaler_reg == LAST);
      prescaler_next = at_last ? '0 : prescaler_reg + PW'(1);
   end

   // Hold the tick low while reset is asserted, so a reset edge never applies a step.
   assign tick = at_last && !rst;

   // Run the prescaler freely. It ignores en and load. Reset drops any partial period.
   always_ff @(posedge clk) begin
      if (rst) begin
         prescaler_reg <= '0;
      end else begin
         prescaler_reg <= prescaler_next;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi = gi + 1) begin : g_ch
         logic [WIDTH-1:0] cnt_reg;
         logic [WIDTH-1:0] cnt_next;
         logic             ovf_reg;
         logic             ovf_next;
         logic [WIDTH:0]   sum_up;
         logic             step_now;
`ifdef TICK_COUNTER_BANK_DOWN_EN
         logic [WIDTH:0]   diff_dn;
`endif

         // Per-channel priority: load, then a tick with en set, then hold.
         // The MSB of the WIDTH+1-bit sum or difference is the carry or borrow.
         always_comb begin
            sum_up   = {1'b0, cnt_reg} + STEP_X;
            step_now = tick && en[gi];
            cnt_next = cnt_reg;
            ovf_next = 1'b0;
`ifdef TICK_COUNTER_BANK_DOWN_EN
            diff_dn  = {1'b0, cnt_reg} - STEP_X;
`endif
            if (load[gi]) begin
               cnt_next = load_val[gi*WIDTH +: WIDTH];
            end else if (step_now) begin
`ifdef TICK_COUNTER_BANK_DOWN_EN
               if (dir[gi]) begin
                  ovf_next = diff_dn[WIDTH];
                  if (SATURATE != 0 && diff_dn[WIDTH]) begin
                     cnt_next = MIN_V;
                  end else begin
                     cnt_next = diff_dn[WIDTH-1:0];
                  end
               end else begin
                  ovf_next = sum_up[WIDTH];
                  if (SATURATE != 0 && sum_up[WIDTH]) begin
                     cnt_next = MAX_V;
                  end else begin
                     cnt_next = sum_up[WIDTH-1:0];
                  end
               end
`else
               ovf_next = sum_up[WIDTH];
               if (SATURATE != 0 && sum_up[WIDTH]) begin
                  cnt_next = MAX_V;
               end else begin
                  cnt_next = sum_up[WIDTH-1:0];
               end
`endif
            end
         end

         // Register the count and the overflow pulse. Reset wins over every other input.
         always_ff @(posedge clk) begin
            if (rst) begin
               cnt_reg <= INIT_V;
               ovf_reg <= 1'b0;
            end else begin
               cnt_reg <= cnt_next;
               ovf_reg <= ovf_next;
            end
         end

         assign o[gi*WIDTH +: WIDTH] = cnt_reg;
         assign ovf[gi]              = ovf_reg;
      end
   endgenerate

endmodule
